inv_cipher_seq: RTL and testbench

- Iterative AES-128 decryption sequencer sitting directly upstream of inv_round.
- Accepts one ciphertext block and performs the initial AddRoundKey with the last round key.
- Drives inv_round once per clock with state, round key and `last` for rounds NR-1 down to 0, registering its result each cycle.
- Presents the plaintext on a valid/ready output; round keys come from an external expanded-key store indexed by this block.

---
 rtl/inv_cipher_seq_if.sv | 14 +
 rtl/inv_cipher_seq.sv | 70 +++++++
 tb/tb_inv_cipher_seq.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_cipher_seq_if.sv
// inv_cipher_seq_if: ciphertext-in / plaintext-out valid-ready handshake bundle
// Ports: in_valid/in_ready/in_data carry ciphertext into the sequencer,
//        out_valid/out_ready/out_data carry plaintext out of it.
//        slave = sequencer side, master = producer/consumer side.
interface inv_cipher_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
endinterface

// File: rtl/inv_cipher_seq.sv
// inv_cipher_seq: iterative AES-128 decryption sequencer driving one external inv_round per clock
// Ports: clk, rst_n (async active-low), abort (sync clear to IDLE),
//        bus (ciphertext in / plaintext out handshake),
//        key_idx/key_in (combinational expanded-key store),
//        rnd_state/rnd_key/rnd_last/rnd_result (inv_round datapath), busy (in ROUND).
module inv_cipher_seq #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               abort,
  inv_cipher_seq_if.slave    bus,
  output logic [KIDX_W-1:0]  key_idx,
  input  logic [127:0]       key_in,
  output logic [127:0]       rnd_state,
  output logic [127:0]       rnd_key,
  output logic               rnd_last,
  input  logic [127:0]       rnd_result,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t            state;
  logic [127:0]      state_reg;
  logic [KIDX_W-1:0] rcnt;
  logic              out_valid;
  logic              accept;
  // a DONE block that is being handed off frees the slot in the same cycle
  assign bus.in_ready  = !abort && (state == IDLE || (state == DONE && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign key_idx       = state == ROUND ? rcnt : KIDX_W'(NR);
  assign rnd_state     = state_reg;
  assign rnd_key       = key_in;
  assign rnd_last      = state == ROUND && rcnt == '0;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = state_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      state_reg <= '0;
      rcnt      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      rcnt      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      state     <= ROUND;
      state_reg <= bus.in_data ^ key_in;
      rcnt      <= KIDX_W'(NR - 1);
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else if (state == ROUND) begin
      state_reg <= rnd_result;
      // finishing at zero takes priority so rcnt never wraps
      if (rcnt == '0) begin
        state     <= DONE;
        out_valid <= 1'b1;
        busy      <= 1'b0;
      end else begin
        rcnt <= rcnt - 1'b1;
      end
    end else if (state == DONE && bus.out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_inv_cipher_seq.sv
// tb_inv_cipher_seq: scoreboard bench for inv_cipher_seq with a behavioural AES model
module tb_inv_cipher_seq;
  localparam int NR = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  inv_cipher_seq_if bus ();
  inv_cipher_seq_if bus2 ();

  logic [3:0]   key_idx;
  logic [127:0] key_in, rnd_state, rnd_key, rnd_result;
  logic         rnd_last, busy;
  logic [127:0] keys [16];
  assign key_in = keys[key_idx];

  inv_cipher_seq #(.NR(NR), .KIDX_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus),
    .key_idx(key_idx), .key_in(key_in), .rnd_state(rnd_state), .rnd_key(rnd_key),
    .rnd_last(rnd_last), .rnd_result(rnd_result), .busy(busy)
  );

  logic [1:0]   key_idx2;
  logic [127:0] key_in2, rnd_state2, rnd_key2, rnd_result2;
  logic         rnd_last2, busy2;
  logic [127:0] keys2 [4];
  assign key_in2     = keys2[key_idx2];
  assign rnd_result2 = rnd_state2 ^ rnd_key2;

  inv_cipher_seq #(.NR(2), .KIDX_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .bus(bus2),
    .key_idx(key_idx2), .key_in(key_in2), .rnd_state(rnd_state2), .rnd_key(rnd_key2),
    .rnd_last(rnd_last2), .rnd_result(rnd_result2), .busy(busy2)
  );

  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- AES reference model ----------------
  logic [7:0] sbox [256];
  logic [7:0] isbox [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = sbox[gb(s, r + 4*((c + r) % 4))];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = isbox[gb(s, r + 4*((c - r + 4) % 4))];
    return o;
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s, input logic [7:0] m0, m1, m2, m3);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gm(m0, gb(s, r + 4*c)) ^ gm(m1, gb(s, (r+1)%4 + 4*c))
                              ^ gm(m2, gb(s, (r+2)%4 + 4*c)) ^ gm(m3, gb(s, (r+3)%4 + 4*c));
    return o;
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // forward cipher: gives the ciphertext whose decryption must be the plaintext
  function automatic logic [127:0] enc(input logic [127:0] p);
    logic [127:0] s = p ^ keys[0];
    for (int r = 1; r < NR; r++) s = mixc(sub_shift(s), 8'd2, 8'd3, 8'd1, 8'd1) ^ keys[r];
    return sub_shift(s) ^ keys[NR];
  endfunction

  // bench-side inv_round
  always_comb
    rnd_result = rnd_last ? inv_sub_shift(rnd_state) ^ rnd_key
                          : mixc(inv_sub_shift(rnd_state) ^ rnd_key, 8'd14, 8'd11, 8'd13, 8'd9);

  // ---------------- scoreboard ----------------
  typedef struct { logic [127:0] d; int c; } exp_t;
  exp_t q [$];
  int last_acc;

  logic [127:0] held;
  bit seen = 0;
  int first = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) seen = 0;
    else if (bus.out_valid) begin
      if (!seen) begin seen = 1; first = cyc; held = bus.out_data; end
      else chk(bus.out_data == held, "out_stable", bus.out_data, held);
      if (bus.out_ready && !abort) begin
        if (q.size() == 0) chk(0, "unexpected_out", bus.out_data, 128'h0);
        else begin
          e = q.pop_front();
          chk(bus.out_data == e.d, "out_data", bus.out_data, e.d);
          chk(first - e.c == NR + 1, "latency", 128'(first - e.c), 128'(NR + 1));
        end
        seen = 0;
      end
    end else seen = 0;
  end

  bit rnd_rdy = 0;
  bit rdy_cmd = 1;
  always @(posedge clk) begin
    #2;
    bus.out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_cmd;
  end

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [127:0] ct, input logic [127:0] exp, input bit push);
    bit ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = ct;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1;
        last_acc = cyc;
        if (push) q.push_back('{exp, cyc});
      end
    end
    if (!ok) chk(0, "accept_timeout", 128'h0, 128'h1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = q.size() == 0 && !bus.out_valid;
    end
    if (!ok) chk(0, "drain_timeout", 128'(q.size()), 128'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string name);
    bit any = 0;
    for (int i = 0; i < NR + 3; i++) begin
      @(negedge clk);
      any |= bus.out_valid;
    end
    chk(!any, name, 128'(any), 128'h0);
  endtask

  initial begin
    logic [7:0]   inv, s;
    logic [127:0] pt, ct, a;
    int           c0, c1;
    bit           ok;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
    for (int i = 0; i < 16; i++) keys[i] = '0;
    expand(128'h000102030405060708090a0b0c0d0e0f);
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.out_ready = 1;

    // reset state
    @(negedge clk);
    chk(bus.out_valid == 0, "rst_out_valid", 128'(bus.out_valid), 128'h0);
    chk(busy == 0, "rst_busy", 128'(busy), 128'h0);
    chk(rnd_last == 0, "rst_rnd_last", 128'(rnd_last), 128'h0);
    chk(bus.in_ready == 1, "rst_in_ready", 128'(bus.in_ready), 128'h1);
    chk(key_idx == 4'(NR), "rst_key_idx", 128'(key_idx), 128'(NR));
    chk(bus.out_data == '0, "rst_out_data", bus.out_data, 128'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 C.1
    send(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 1);
    for (int i = 0; i < NR; i++) begin
      @(negedge clk);
      chk(key_idx == 4'(NR - 1 - i), "round_key_idx", 128'(key_idx), 128'(NR - 1 - i));
      chk(rnd_last == (i == NR - 1), "round_last", 128'(rnd_last), 128'(i == NR - 1));
      chk(busy && !bus.in_ready, "round_busy", 128'({busy, bus.in_ready}), 128'b10);
    end
    drain();

    // back-to-back
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(enc(pt), pt, 1);
    c0 = last_acc;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(enc(pt), pt, 1);
    c1 = last_acc;
    chk(c1 - c0 == NR + 1, "b2b_accept", 128'(c1 - c0), 128'(NR + 1));
    drain();

    // backpressure
    rdy_cmd = 0;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(enc(pt), pt, 1);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = bus.out_valid; end
    chk(ok, "bp_out_valid", 128'(ok), 128'h1);
    @(posedge clk);
    #1 bus.in_valid = 1; bus.in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk(!bus.in_ready && !busy && bus.out_valid, "bp_stall", 128'({bus.in_ready, busy, bus.out_valid}), 128'b001);
    end
    @(posedge clk);
    #1 bus.in_valid = 0; rdy_cmd = 1;
    @(negedge clk);
    @(negedge clk);
    chk(!bus.out_valid && bus.in_ready && !busy, "bp_idle", 128'({bus.out_valid, bus.in_ready, busy}), 128'b010);
    drain();

    // abort in the 4th ROUND cycle
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(enc(pt), pt, 0);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1; bus.in_valid = 1; bus.in_data = enc(pt);
    @(negedge clk);
    chk(!bus.in_ready, "abort_in_ready", 128'(bus.in_ready), 128'h0);
    @(posedge clk);
    #1 abort = 0; bus.in_valid = 0;
    @(negedge clk);
    chk(bus.in_ready && !busy && !bus.out_valid, "abort_idle", 128'({bus.in_ready, busy, bus.out_valid}), 128'b100);
    quiet("abort_no_out");
    @(posedge clk);
    #1;
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(enc(pt), pt, 1);
    drain();

    // async reset in the final ROUND cycle
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(enc(pt), pt, 0);
    repeat (NR) @(negedge clk);
    chk(busy && rnd_last, "pre_rst_round", 128'({busy, rnd_last}), 128'b11);
    #1 rst_n = 0;
    #1 chk(!busy && !rnd_last && !bus.out_valid, "rst_async", 128'({busy, rnd_last, bus.out_valid}), 128'b000);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk(bus.in_ready, "rst_release_ready", 128'(bus.in_ready), 128'h1);
    quiet("rst_no_out");
    @(posedge clk);
    #1;

    // randomized traffic, two keys, random backpressure
    rnd_rdy = 1;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) expand({$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < 10; i++) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        send(enc(pt), pt, 1);
        repeat ($urandom_range(0, 3) * 4) begin @(posedge clk); #1; end
      end
      drain();
    end
    rnd_rdy = 0;
    @(posedge clk);
    #1;

    // NR=2 build with XOR stub round
    for (int i = 0; i < 3; i++) keys2[i] = {$urandom, $urandom, $urandom, $urandom};
    keys2[3] = '0;
    a = {$urandom, $urandom, $urandom, $urandom};
    bus2.in_valid = 1; bus2.in_data = a;
    @(negedge clk);
    chk(bus2.in_ready && key_idx2 == 2'd2, "nr2_accept", 128'({bus2.in_ready, key_idx2}), 128'b110);
    c0 = cyc;
    @(posedge clk);
    #1 bus2.in_valid = 0;
    @(negedge clk);
    chk(busy2 && key_idx2 == 2'd1 && !rnd_last2, "nr2_round1", 128'({busy2, key_idx2, rnd_last2}), 128'b1010);
    @(negedge clk);
    chk(busy2 && key_idx2 == 2'd0 && rnd_last2, "nr2_round0", 128'({busy2, key_idx2, rnd_last2}), 128'b1001);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      ok = bus2.out_valid;
    end
    if (!ok) @(negedge clk);
    chk(ok && cyc - c0 == 3, "nr2_latency", 128'(cyc - c0), 128'h3);
    chk(bus2.out_data == (a ^ keys2[2] ^ keys2[1] ^ keys2[0]), "nr2_data", bus2.out_data, a ^ keys2[2] ^ keys2[1] ^ keys2[0]);

    @(posedge clk);
    #1;
    chk(q.size() == 0, "sb_empty", 128'(q.size()), 128'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
